// File: rtl/edge_map_writer.sv
// edge_map_writer: packs a raster edge stream into bytes for the edge-map RAM, with optional border masking
module edge_map_writer #(
  parameter int W = 224,
  parameter int H = 224,
  parameter int ADDR_W = 13,
  parameter bit MASK_BORDER = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic              pix_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       edge_count
);
  localparam int CW = $clog2(W);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, mem_addr_q, mem_addr_d;
  logic [7:0] shreg_q, shreg_d, mem_data_q, mem_data_d;
  logic mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d;
  logic [15:0] edge_count_q, edge_count_d;
  logic col_end, border, p;
  always_comb begin
    col_end = col_q == CW'(W - 1);
    border = col_q == '0 || col_end || row_q == '0 || row_q == RW'(H - 1);
    p = pix_in & ~(MASK_BORDER & border);
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    bit_cnt_d = bit_cnt_q;
    idx_d = idx_q;
    shreg_d = shreg_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d = busy_q;
    done_d = done_q;
    edge_count_d = edge_count_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = RUN;
      col_d = '0;
      row_d = '0;
      bit_cnt_d = '0;
      idx_d = '0;
      shreg_d = '0;
      edge_count_d = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (state_q == RUN && pix_valid) begin
      shreg_d[bit_cnt_q] = p;
      edge_count_d = edge_count_q + {15'd0, p & ~&edge_count_q};
      col_d = col_end ? '0 : col_q + CW'(1);
      row_d = col_end ? row_q + RW'(1) : row_q;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (&bit_cnt_q) begin
        mem_we_d = 1'b1;
        mem_addr_d = idx_q;
        mem_data_d = {p, shreg_q[6:0]};
        idx_d = idx_q + ADDR_W'(1);
      end
      if (col_end && row_q == RW'(H - 1)) state_d = LAST;
    end else if (state_q == LAST) begin
      state_d = DONE;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      bit_cnt_q <= '0;
      idx_q <= '0;
      shreg_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      edge_count_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q <= idx_d;
      shreg_q <= shreg_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      edge_count_q <= edge_count_d;
    end
  end
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign edge_count = edge_count_q;
endmodule

// File: tb/tb_edge_map_writer.sv
// tb_edge_map_writer: directed bench on 16x16 frames, one unmasked and one border-masked instance
module tb_edge_map_writer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_valid = 1'b0, pix_in = 1'b0;
  logic we0, we1, busy0, busy1, done0, done1;
  logic [4:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic [15:0] cnt0, cnt1;
  int n_vec = 0, n_err = 0, nw0 = 0, nw1 = 0, dbl = 0;
  int wa0[64], wd0[64], wa1[64], wd1[64];
  logic prev0 = 1'b0, prev1 = 1'b0;
  always #5 clk = ~clk;
  edge_map_writer #(.W(16), .H(16), .ADDR_W(5), .MASK_BORDER(1'b0)) u_plain (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .mem_we(we0), .mem_addr(addr0), .mem_data(data0), .busy(busy0), .done(done0), .edge_count(cnt0));
  edge_map_writer #(.W(16), .H(16), .ADDR_W(5), .MASK_BORDER(1'b1)) u_mask (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .mem_we(we1), .mem_addr(addr1), .mem_data(data1), .busy(busy1), .done(done1), .edge_count(cnt1));
  always @(negedge clk) begin
    if (we0 && nw0 < 64) begin wa0[nw0] = int'(addr0); wd0[nw0] = int'(data0); end
    if (we1 && nw1 < 64) begin wa1[nw1] = int'(addr1); wd1[nw1] = int'(data1); end
    if (we0) nw0++;
    if (we1) nw1++;
    if ((we0 && prev0) || (we1 && prev1)) dbl++;
    prev0 = we0;
    prev1 = we1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic bit pat(input int mode, input int i);
    logic [7:0] a5 = 8'hA5;
    if (mode == 1) return 1'b1;
    if (i < 8) return a5[i];
    return 1'(((i * 37) >> 2) & 1);
  endfunction
  function automatic bit keep(input bit mask, input int i);
    int r = i / 16, c = i % 16;
    return !(mask && (r == 0 || r == 15 || c == 0 || c == 15));
  endfunction
  function automatic int exp_byte(input int mode, input bit mask, input int a);
    logic [7:0] e = '0;
    for (int k = 0; k < 8; k++) e[k] = pat(mode, 8 * a + k) & keep(mask, 8 * a + k);
    return int'(e);
  endfunction
  function automatic int exp_cnt(input int mode, input bit mask);
    int s = 0;
    for (int i = 0; i < 256; i++) s += int'(pat(mode, i) & keep(mask, i));
    return s;
  endfunction
  task automatic cyc(input logic v, input logic p);
    pix_valid = v;
    pix_in = p;
    @(negedge clk);
  endtask
  task automatic do_start(input logic sv);
    start = 1'b1;
    pix_valid = sv;
    pix_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_valid = 1'b0;
    chk("start_busy", int'(busy0), 1);
    chk("start_done", int'(done1), 0);
    chk("start_cnt", int'(cnt0), 0);
  endtask
  task automatic run_frame(input int mode, input bit gappy, input logic sv);
    nw0 = 0;
    nw1 = 0;
    do_start(sv);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, pat(mode, i));
      if (gappy && i < 255) begin
        int g = $urandom_range(0, 5);
        for (int j = 0; j <= g; j++) begin
          start = ($urandom_range(0, 3) == 0);
          cyc(1'b0, 1'($urandom));
        end
        start = 1'b0;
      end
    end
    chk("last_we", int'(we0), 1);
    chk("last_addr", int'(addr1), 31);
    chk("last_done", int'(done0), 0);
    chk("last_busy", int'(busy1), 1);
    cyc(1'b0, 1'b0);
    chk("fin_done", int'(done1), 1);
    chk("fin_busy", int'(busy0), 0);
    chk("fin_we", int'(we0), 0);
    chk("n_writes0", nw0, 32);
    chk("n_writes1", nw1, 32);
    for (int a = 0; a < 32 && a < nw0 && a < nw1; a++) begin
      chk($sformatf("addr0[%0d]", a), wa0[a], a);
      chk($sformatf("data0[%0d]", a), wd0[a], exp_byte(mode, 1'b0, a));
      chk($sformatf("addr1[%0d]", a), wa1[a], a);
      chk($sformatf("data1[%0d]", a), wd1[a], exp_byte(mode, 1'b1, a));
    end
    chk("count0", int'(cnt0), exp_cnt(mode, 1'b0));
    chk("count1", int'(cnt1), exp_cnt(mode, 1'b1));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, int'(we0 | we1), 0);
    chk({tag, "_addr"}, int'(addr0 | addr1), 0);
    chk({tag, "_data"}, int'(data0 | data1), 0);
    chk({tag, "_busy"}, int'(busy0 | busy1), 0);
    chk({tag, "_done"}, int'(done0 | done1), 0);
    chk({tag, "_cnt"}, int'(cnt0 | cnt1), 0);
  endtask
  initial begin
    int snap, csnap;
    repeat (2) begin
      start = 1'($urandom);
      pix_valid = 1'($urandom);
      pix_in = 1'($urandom);
      @(negedge clk);
    end
    chk_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (3) cyc(1'b1, 1'b1);
    chk("idle_writes", nw0 + nw1, 0);
    chk_zero("idle");
    run_frame(0, 1'b0, 1'b0);
    chk("bitorder_a5", wd0[0], 'hA5);
    run_frame(1, 1'b0, 1'b0);
    chk("mask_a0", wd1[0], 'h00);
    chk("mask_a1", wd1[1], 'h00);
    chk("mask_a2", wd1[2], 'hFE);
    chk("mask_a3", wd1[3], 'h7F);
    chk("mask_a30", wd1[30], 'h00);
    chk("mask_a31", wd1[31], 'h00);
    chk("mask_cnt", int'(cnt1), 196);
    chk("plain_cnt", int'(cnt0), 256);
    run_frame(1, 1'b1, 1'b1);
    chk("gappy_cnt", int'(cnt1), 196);
    chk("gappy_a2", wd1[2], 'hFE);
    snap = nw0;
    csnap = int'(cnt1);
    repeat (5) cyc(1'b1, 1'b1);
    chk("done_no_write", nw0, snap);
    chk("done_no_count", int'(cnt1), csnap);
    chk("done_held", int'(done1), 1);
    do_start(1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1);
    chk("pre_rst_writes", nw0, snap + 12);
    rst = 1'b1;
    pix_valid = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    snap = nw0;
    repeat (20) cyc(1'b1, 1'b1);
    chk("post_rst_writes", nw0, snap);
    run_frame(0, 1'b0, 1'b0);
    chk("no_back_to_back", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
